mem_port_arbiter: RTL and testbench

- Shares one memory/peripheral bus port between the instruction-fetch stage and the MEM stage of the 5-stage pipeline.
- The bus port has variable-latency req/ack timing.
- The block grants the bus to one requester per transaction and returns read data. It gives each requester a one-cycle ready pulse, which the pipeline uses as its advance/stall condition.
- A timeout guards against peripherals that never acknowledge.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter_timeout_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for mem_port_arbiter: FSM states, owner IDs and bus op-length codes.
// Optional starvation guard is enabled with `define ARB_STARVATION_GUARD_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2,
        ARB_DONE     = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IF  = 1'b0,
        ARB_OWNER_MEM = 1'b1
    } arb_owner_e;

    // Access size codes shared with the load/store decoder; fetches always use word.
    localparam logic [2:0] OP_LEN_BYTE = 3'b000;
    localparam logic [2:0] OP_LEN_HALF = 3'b001;
    localparam logic [2:0] OP_LEN_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory bus signals around mem_port_arbiter.
// Handshake: a requester holds x_req and its payload until the single-cycle x_ready pulse; the memory answers a held bus_req with a single-cycle bus_ack.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_address;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_op_length;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_op_length;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        err_timeout;

    modport slave (
        input  if_req, if_address, mem_req, mem_write, mem_address, mem_wdata,
               mem_op_length, bus_rdata, bus_ack,
        output if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_write,
               bus_address, bus_wdata, bus_op_length, err_timeout
    );

    modport master (
        output if_req, if_address, mem_req, mem_write, mem_address, mem_wdata,
               mem_op_length, bus_rdata, bus_ack,
        input  if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_write,
               bus_address, bus_wdata, bus_op_length, err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Counts bus cycles without an acknowledge; expired is asserted combinationally in the cycle that would reach TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables the timeout.
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] count;

            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= count + 1'b1;
                end
            end

            assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency bus port between instruction fetch and the MEM stage.
// Optional feature macro: ARB_STARVATION_GUARD_EN (forces a fetch grant after MAX_DATA_BURST data grants).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_port_arbiter_if.slave     port,
    output arb_state_e            state_dbg
);
    arb_state_e  state_q, state_next;
    arb_owner_e  owner_q, owner_next;
    logic        bus_write_q, bus_write_next;
    logic [31:0] bus_address_q, bus_address_next;
    logic [31:0] bus_wdata_q, bus_wdata_next;
    logic [2:0]  bus_op_length_q, bus_op_length_next;
    logic [31:0] if_rdata_q, if_rdata_next;
    logic [31:0] mem_rdata_q, mem_rdata_next;
    logic        timed_out_q, timed_out_next;
    logic        busy, expired, fetch_forced, grant_mem, grant_if;

    assign busy = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_MEM);

    arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy && !port.bus_ack),
        .expired (expired)
    );

`ifdef ARB_STARVATION_GUARD_EN
    localparam int BURST_W = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;
    logic [BURST_W-1:0] burst_q;

    assign fetch_forced = (burst_q == BURST_W'(MAX_DATA_BURST));

    // Only grants made in IDLE touch the burst count; it saturates at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            burst_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (grant_if) begin
                burst_q <= '0;
            end else if (grant_mem) begin
                if (!port.if_req) begin
                    burst_q <= '0;
                end else if (!fetch_forced) begin
                    burst_q <= burst_q + 1'b1;
                end
            end
        end
    end
`else
    assign fetch_forced = 1'b0;
`endif

    assign grant_mem = port.mem_req && !(port.if_req && fetch_forced);
    assign grant_if  = port.if_req && !grant_mem;

    always_comb begin
        state_next         = state_q;
        owner_next         = owner_q;
        bus_write_next     = bus_write_q;
        bus_address_next   = bus_address_q;
        bus_wdata_next     = bus_wdata_q;
        bus_op_length_next = bus_op_length_q;
        if_rdata_next      = if_rdata_q;
        mem_rdata_next     = mem_rdata_q;
        timed_out_next     = timed_out_q;
        case (state_q)
            ARB_IDLE: begin
                timed_out_next = 1'b0;
                if (grant_mem) begin
                    state_next         = ARB_BUSY_MEM;
                    owner_next         = ARB_OWNER_MEM;
                    bus_write_next     = port.mem_write;
                    bus_address_next   = port.mem_address;
                    bus_wdata_next     = port.mem_wdata;
                    bus_op_length_next = port.mem_op_length;
                end else if (grant_if) begin
                    state_next         = ARB_BUSY_IF;
                    owner_next         = ARB_OWNER_IF;
                    bus_write_next     = 1'b0;
                    bus_address_next   = port.if_address;
                    bus_wdata_next     = '0;
                    bus_op_length_next = OP_LEN_WORD;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                // An ack in the expiry cycle wins, so no error is raised then.
                if (port.bus_ack) begin
                    state_next = ARB_DONE;
                    if (owner_q == ARB_OWNER_IF) begin
                        if_rdata_next = port.bus_rdata;
                    end else if (!bus_write_q) begin
                        mem_rdata_next = port.bus_rdata;
                    end
                end else if (expired) begin
                    state_next     = ARB_DONE;
                    timed_out_next = 1'b1;
                    if (owner_q == ARB_OWNER_IF) begin
                        if_rdata_next = '0;
                    end else begin
                        mem_rdata_next = '0;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ARB_IDLE;
            owner_q         <= ARB_OWNER_IF;
            bus_write_q     <= 1'b0;
            bus_address_q   <= '0;
            bus_wdata_q     <= '0;
            bus_op_length_q <= '0;
            if_rdata_q      <= '0;
            mem_rdata_q     <= '0;
            timed_out_q     <= 1'b0;
        end else begin
            state_q         <= state_next;
            owner_q         <= owner_next;
            bus_write_q     <= bus_write_next;
            bus_address_q   <= bus_address_next;
            bus_wdata_q     <= bus_wdata_next;
            bus_op_length_q <= bus_op_length_next;
            if_rdata_q      <= if_rdata_next;
            mem_rdata_q     <= mem_rdata_next;
            timed_out_q     <= timed_out_next;
        end
    end

    assign port.bus_req       = busy;
    assign port.bus_write     = bus_write_q;
    assign port.bus_address   = bus_address_q;
    assign port.bus_wdata     = bus_wdata_q;
    assign port.bus_op_length = bus_op_length_q;
    assign port.if_rdata      = if_rdata_q;
    assign port.mem_rdata     = mem_rdata_q;
    assign port.if_ready      = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_IF);
    assign port.mem_ready     = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_MEM);
    assign port.err_timeout   = (state_q == ARB_DONE) && timed_out_q;
    assign state_dbg          = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main thread drives requests and plays the memory,
// a negedge monitor pops expected completions {is_mem, err, rdata} from exp_q and compares.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    arb_state_e  state_dbg;
    int          checks;
    int          errors;
    logic [33:0] exp_q[$];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(16), .MAX_DATA_BURST(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .port      (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [33:0] exp_entry(input logic is_mem, input logic err, input logic [31:0] rdata);
        return {is_mem, err, rdata};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"},   32'(bus.bus_req), 32'd0);
        check({tag, "_bus_write"}, 32'(bus.bus_write), 32'd0);
        check({tag, "_bus_addr"},  bus.bus_address, 32'd0);
        check({tag, "_bus_wdata"}, bus.bus_wdata, 32'd0);
        check({tag, "_bus_oplen"}, 32'(bus.bus_op_length), 32'd0);
        check({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
        check({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
        check({tag, "_if_ready"},  32'(bus.if_ready), 32'd0);
        check({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'd0);
        check({tag, "_err"},       32'(bus.err_timeout), 32'd0);
        check({tag, "_state"},     32'(state_dbg), 32'(ARB_IDLE));
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [33:0] e;
        if (bus.if_ready || bus.mem_ready) begin
            check("ready_exclusive", 32'(bus.if_ready && bus.mem_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'(bus.mem_ready), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("ready_source", 32'(bus.mem_ready), 32'(e[33]));
                check("err_timeout", 32'(bus.err_timeout), 32'(e[32]));
                check("rdata", bus.mem_ready ? bus.mem_rdata : bus.if_rdata, e[31:0]);
            end
        end else if (bus.err_timeout) begin
            check("err_without_ready", 32'(bus.err_timeout), 32'd0);
        end
    end

    initial begin
        int n;
        bit exp_is_mem [6];
        checks = 0;
        errors = 0;
`ifdef ARB_STARVATION_GUARD_EN
        exp_is_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_is_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        reset = 1'b1;
        bus.if_req = 0; bus.if_address = 0;
        bus.mem_req = 0; bus.mem_write = 0; bus.mem_address = 0;
        bus.mem_wdata = 0; bus.mem_op_length = 0;
        bus.bus_rdata = 0; bus.bus_ack = 0;
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // fetch with ack in the first BUSY cycle
        exp_q.push_back(exp_entry(1'b0, 1'b0, 32'h0050_0093));
        bus.if_req = 1; bus.if_address = 32'h10;
        tick();
        check("f_bus_req", 32'(bus.bus_req), 32'd1);
        check("f_bus_addr", bus.bus_address, 32'h10);
        check("f_bus_oplen", 32'(bus.bus_op_length), 32'(OP_LEN_WORD));
        check("f_bus_write", 32'(bus.bus_write), 32'd0);
        bus.bus_ack = 1; bus.bus_rdata = 32'h0050_0093;
        tick();
        bus.bus_ack = 0; bus.if_req = 0;
        check("f_latency_ready", 32'(bus.if_ready), 32'd1);
        check("f_done_bus_req", 32'(bus.bus_req), 32'd0);
        tick();

        // both request: data wins, fetch granted right after DONE
        exp_q.push_back(exp_entry(1'b1, 1'b0, 32'h0000_CAFE));
        exp_q.push_back(exp_entry(1'b0, 1'b0, 32'h0000_0013));
        bus.if_req = 1; bus.if_address = 32'h20;
        bus.mem_req = 1; bus.mem_write = 0; bus.mem_address = 32'h100; bus.mem_op_length = OP_LEN_WORD;
        tick();
        check("pri_state", 32'(state_dbg), 32'(ARB_BUSY_MEM));
        check("pri_bus_addr", bus.bus_address, 32'h100);
        bus.bus_ack = 1; bus.bus_rdata = 32'h0000_CAFE;
        tick();
        bus.bus_ack = 0; bus.mem_req = 0;
        check("pri_mem_ready", 32'(bus.mem_ready), 32'd1);
        tick();
        check("pri_idle_gap", 32'(state_dbg), 32'(ARB_IDLE));
        tick();
        check("pri_if_state", 32'(state_dbg), 32'(ARB_BUSY_IF));
        check("pri_if_addr", bus.bus_address, 32'h20);
        bus.bus_ack = 1; bus.bus_rdata = 32'h13;
        tick();
        bus.bus_ack = 0; bus.if_req = 0;
        tick();

        // byte store, ack in the third BUSY cycle; mem_rdata keeps 0xCAFE
        exp_q.push_back(exp_entry(1'b1, 1'b0, 32'h0000_CAFE));
        bus.mem_req = 1; bus.mem_write = 1; bus.mem_address = 32'h200;
        bus.mem_wdata = 32'h1234; bus.mem_op_length = OP_LEN_BYTE;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("st_bus_req", 32'(bus.bus_req), 32'd1);
            check("st_bus_write", 32'(bus.bus_write), 32'd1);
            check("st_bus_wdata", bus.bus_wdata, 32'h1234);
            check("st_bus_oplen", 32'(bus.bus_op_length), 32'(OP_LEN_BYTE));
            if (i == 2) begin
                bus.bus_ack = 1; bus.bus_rdata = 32'hBAD0_BAD0;
            end
            tick();
        end
        bus.bus_ack = 0; bus.mem_req = 0; bus.mem_write = 0;
        check("st_mem_ready", 32'(bus.mem_ready), 32'd1);
        tick();

        // no ack: aborted after exactly 16 bus cycles
        exp_q.push_back(exp_entry(1'b1, 1'b1, 32'h0));
        bus.mem_req = 1; bus.mem_address = 32'h300; bus.mem_op_length = OP_LEN_WORD;
        tick();
        n = 0;
        while (bus.bus_req && n < 40) begin
            n++;
            tick();
        end
        check("to_bus_req_cycles", 32'(n), 32'd16);
        check("to_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("to_err", 32'(bus.err_timeout), 32'd1);
        bus.mem_req = 0;
        tick();

        // ack in the expiry cycle wins: no error
        exp_q.push_back(exp_entry(1'b1, 1'b0, 32'h0000_BEEF));
        bus.mem_req = 1; bus.mem_address = 32'h400;
        tick();
        repeat (15) tick();
        check("race_still_busy", 32'(bus.bus_req), 32'd1);
        bus.bus_ack = 1; bus.bus_rdata = 32'h0000_BEEF;
        tick();
        bus.bus_ack = 0; bus.mem_req = 0;
        tick();

        // reset in the second BUSY cycle, then a late ack
        bus.if_req = 1; bus.if_address = 32'h40;
        tick();
        tick();
        check("rst_busy2", 32'(state_dbg), 32'(ARB_BUSY_IF));
        reset = 1'b1; bus.if_req = 0;
        tick();
        reset = 1'b0;
        bus.bus_ack = 1; bus.bus_rdata = 32'h0000_DEAD;
        check_all_zero("rst_mid");
        tick();
        bus.bus_ack = 0;
        check("rst_late_ack_state", 32'(state_dbg), 32'(ARB_IDLE));
        check("rst_late_ack_rdata", bus.if_rdata, 32'd0);
        tick();

        // both requests held continuously: grant order
        bus.if_req = 1; bus.if_address = 32'h80;
        bus.mem_req = 1; bus.mem_write = 0; bus.mem_address = 32'h500;
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (!bus.bus_req && n < 10) begin
                n++;
                tick();
            end
            check("grant_wait", 32'(n < 10), 32'd1);
            check("grant_order", 32'(state_dbg), exp_is_mem[t] ? 32'(ARB_BUSY_MEM) : 32'(ARB_BUSY_IF));
            exp_q.push_back(exp_entry(exp_is_mem[t], 1'b0, 32'h1000 + 32'(t)));
            bus.bus_ack = 1; bus.bus_rdata = 32'h1000 + 32'(t);
            tick();
            bus.bus_ack = 0;
            tick();
        end
        bus.if_req = 0; bus.mem_req = 0;
        repeat (4) tick();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
